// File: rtl/config_timer.sv
// Three-phase traffic timer (GREEN/YELLOW/RED).
// Emits a registered one-cycle strobe at each phase expiry.
module config_timer #(
  parameter int GREEN_CYCLES  = 10,
  parameter int YELLOW_CYCLES = 3,
  parameter int RED_CYCLES    = 12,
  parameter int CNT_W = $clog2(
    (GREEN_CYCLES > YELLOW_CYCLES)
      ? ((GREEN_CYCLES > RED_CYCLES)
          ? GREEN_CYCLES : RED_CYCLES)
      : ((YELLOW_CYCLES > RED_CYCLES)
          ? YELLOW_CYCLES : RED_CYCLES)) + 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic signal_change
);

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    ILLEGAL = 2'd3
  } phase_t;

  if (GREEN_CYCLES < 1) begin : g_bad_green
    $error("GREEN_CYCLES must be >= 1");
  end
  if (YELLOW_CYCLES < 1) begin : g_bad_yellow
    $error("YELLOW_CYCLES must be >= 1");
  end
  if (RED_CYCLES < 1) begin : g_bad_red
    $error("RED_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] G_LAST =
    CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST =
    CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LAST =
    CNT_W'(RED_CYCLES - 1);

  phase_t           phase;
  phase_t           next_phase;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] last;
  logic             legal;

  // Terminal count and successor of the current phase.
  always_comb begin
    last       = '0;
    next_phase = GREEN;
    legal      = 1'b1;
    case (phase)
      GREEN: begin
        last       = G_LAST;
        next_phase = YELLOW;
      end
      YELLOW: begin
        last       = Y_LAST;
        next_phase = RED;
      end
      RED: begin
        last       = R_LAST;
        next_phase = GREEN;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Phase counter; an illegal phase recovers to GREEN silently.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      phase         <= GREEN;
      count         <= '0;
      signal_change <= 1'b0;
    end else if (!legal) begin
      phase         <= GREEN;
      count         <= '0;
      signal_change <= 1'b0;
    end else if (count == last) begin
      phase         <= next_phase;
      count         <= '0;
      signal_change <= 1'b1;
    end else begin
      count         <= count + 1'b1;
      signal_change <= 1'b0;
    end
  end

endmodule

// File: tb/tb_config_timer.sv
// Scoreboard bench for config_timer.
// Two instances: default durations and 1/1/2.
module tb_config_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sc_a;
  logic sc_b;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int strobes = 0;

  bit exp_a[$];
  bit exp_b[$];

  always #5 clk = ~clk;

  config_timer dut (
    .clk(clk),
    .rst_n(rst_n),
    .signal_change(sc_a)
  );

  config_timer #(
    .GREEN_CYCLES(1),
    .YELLOW_CYCLES(1),
    .RED_CYCLES(2)
  ) dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .signal_change(sc_b)
  );

  // Hand-derived strobe edges: default period 25
  // with strobes at 10,13,25; small config period 4
  // with strobes at 1,2,4.
  function automatic bit want_a(int e);
    int m;
    m = e % 25;
    return (e > 0) && (m == 10 || m == 13 || m == 0);
  endfunction

  function automatic bit want_b(int e);
    int m;
    m = e % 4;
    return (e > 0) && (m == 1 || m == 2 || m == 0);
  endfunction

  task automatic step(input logic r);
    #1 rst_n = r;
    @(posedge clk);
    if (r) edge_n = 0;
    else edge_n++;
    exp_a.push_back(r ? 1'b0 : want_a(edge_n));
    exp_b.push_back(r ? 1'b0 : want_b(edge_n));
  endtask

  task automatic run(input logic r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  task automatic check_int(input string nm,
                           input int got,
                           input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d",
               nm, got, want);
    end
  endtask

  // Monitor: pops the expected value for each edge.
  initial begin
    bit ea;
    bit eb;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        ea = exp_a.pop_front();
        eb = exp_b.pop_front();
        checks += 2;
        if (sc_a !== ea) begin
          errors++;
          $display("FAIL sc_dflt t=%0t got %b want %b",
                   $time, sc_a, ea);
        end
        if (sc_b !== eb) begin
          errors++;
          $display("FAIL sc_112 t=%0t got %b want %b",
                   $time, sc_b, eb);
        end
        if (sc_a === 1'b1) strobes++;
      end
    end
  end

  initial begin
    run(1'b1, 1);
    @(negedge clk); #1;
    check_int("rst_phase", int'(dut.phase), 0);
    check_int("rst_count", int'(dut.count), 0);

    run(1'b0, 60);

    run(1'b1, 1);
    run(1'b0, 26);
    run(1'b1, 28);
    run(1'b0, 30);

    run(1'b1, 1);
    run(1'b0, 12);
    run(1'b1, 1);
    run(1'b0, 15);

    run(1'b1, 1);
    @(negedge clk); #1;
    strobes = 0;
    run(1'b0, 200);
    @(negedge clk); #1;
    check_int("strobes_200", strobes, 24);

    run(1'b1, 121);
    @(negedge clk); #1;
    check_int("hold_phase", int'(dut.phase), 0);
    check_int("hold_count", int'(dut.count), 0);
    check_int("hold_phase_b", int'(dut_b.phase), 0);

    run(1'b0, 14);
    @(negedge clk); #1;
    check_int("drain", exp_a.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_timer.md
# config_timer

Free-running, parameterised phase timer for the traffic controller. It sequences three timed phases (GREEN, YELLOW, RED) and emits a single-cycle `signal_change` strobe each time a phase expires. The downstream light-control logic uses the strobe to advance the lamp outputs. The block has no data inputs; its behaviour is fixed by parameters and reset.

## Interface

Parameters:
- `GREEN_CYCLES`, default 10: length of the GREEN phase in clock cycles; must be ≥ 1.
- `YELLOW_CYCLES`, default 3: length of the YELLOW phase in clock cycles; must be ≥ 1.
- `RED_CYCLES`, default 12: length of the RED phase in clock cycles; must be ≥ 1.
- `CNT_W`, default `$clog2(max(GREEN_CYCLES,YELLOW_CYCLES,RED_CYCLES))+1`: width of the phase counter.

Ports:
- `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: one clock; reset is synchronous and active-high. Reset is asserted while `rst_n` = 1, sampled on the `clk` rising edge.
- `signal_change`, output, 1 bit: registered one-cycle strobe marking the end of a phase.

## Operation

- Internal state:
  - `phase`, 2-bit encoded: GREEN = 0, YELLOW = 1, RED = 2; value 3 is illegal.
  - `count`, `CNT_W` bits.
- Phase durations: `DUR(GREEN)=GREEN_CYCLES`, `DUR(YELLOW)=YELLOW_CYCLES`, `DUR(RED)=RED_CYCLES`.
- Phase sequence: GREEN → YELLOW → RED → GREEN, wrapping indefinitely.
- Reset (`rst_n` = 1 at an edge) loads `phase` = GREEN, `count` = 0, `signal_change` = 0. Reset has priority over all counting.
- Each non-reset edge:
  - If `count == DUR(phase)-1`: `count` ← 0, `phase` ← next phase, `signal_change` ← 1.
  - Otherwise: `count` ← `count`+1, `signal_change` ← 0.
- Illegal `phase` value 3: the next non-reset edge forces `phase` = GREEN, `count` = 0, `signal_change` = 0.
- A duration of 1 makes that phase last exactly one cycle; its strobe immediately follows the previous phase's strobe, giving back-to-back strobes.
- Elaboration must fail (assertion) if any duration is < 1.

## Timing

- All outputs are registered; there is no combinational path to `signal_change`.
- Counting edge numbering: edge 1 is the first rising edge at which reset is sampled deasserted.
- First strobe: `signal_change` goes high after edge `GREEN_CYCLES` and stays high for exactly one cycle.
- Subsequent strobe edges: `G+Y`, `G+Y+R`, then repeating with period `P = G+Y+R` (G, Y, R are the three durations).
  - Defaults: strobes follow edges 10, 13, 25, 35, 38, 50, …
- Reset mid-phase, including on the exact edge a strobe would fire: the strobe is suppressed and the block restarts from GREEN / `count` 0.
- Edge numbering restarts at the first edge after reset deasserts.
- Reset held for N cycles: `signal_change` = 0 throughout, and state stays frozen at GREEN / 0.
- `signal_change` is never high for two consecutive cycles unless a phase duration is 1.

## Test plan

- Defaults: hold reset 1 cycle, then run 60 cycles → `signal_change` high exactly after edges 10, 13, 25, 35, 38, 50; low on all other cycles.
- Assert reset at edge 27 and hold 28 cycles → `signal_change` = 0 during reset. After release, the first strobe follows edge 10 of the new count, not a continuation of the old one.
- Reset asserted exactly on edge 13 → no strobe for that edge. The next strobe follows edge 10 after release.
- Run 200 cycles after reset → exactly 24 strobes (8 full periods of 25); every strobe is 1 cycle wide.
- With `GREEN_CYCLES=1`, `YELLOW_CYCLES=1`, `RED_CYCLES=2` → strobes follow edges 1, 2, 4, 5, 6, 8, …, with period 4.
- Hold reset asserted continuously for 121 cycles → `signal_change` = 0 throughout and internal state stays at GREEN / 0.
